count_capture_fifo: RTL and testbench
=====================================

Name: count_capture_fifo

Overview:
- Downstream consumer of the 4-bit up-counter's `count` output.
- On each rising edge of an event input (`trig`), snapshots the current counter value into a small FIFO.
- Presents captured values to a sink through a valid/ready interface.
- Provides full/empty/level status and a sticky overflow flag for dropped events.

Parameters:
- WIDTH, 4, width of the `count` input and of each captured value.
- DEPTH, 4, FIFO entries; power of 2, DEPTH >= 2.
- EXT_W, 4, wrap-extension bits prepended to captured data (used only when CAP_WRAP_EXT_EN is defined).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- count  input  WIDTH  live counter value from the upstream counter.
- trig  input  1  capture event, synchronous to clk; rising edge triggers capture.
- clr_ovf  input  1  clears the sticky overflow flag.
- cap_ready  input  1  sink ready.
- cap_valid  output  1  FIFO non-empty; head entry on cap_data.
- cap_data  output  DW  head entry; DW = WIDTH, or EXT_W+WIDTH with CAP_WRAP_EXT_EN.
- level  output  $clog2(DEPTH)+1  number of stored entries.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and level cleared to 0; overflow = 0; cap_valid = 0; empty = 1; full = 0; cap_data = 0.
  - trig_q (registered trig) resets to 1, so a trig held high across reset release does not produce a capture.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all entries immediately.
- Edge detect:
  - push_req = trig & ~trig_q, evaluated at a posedge; trig_q <= trig every cycle.
  - trig held high yields exactly one capture.
  - Back-to-back captures need trig low for at least one cycle between edges.
- Capture:
  - On push_req the value of `count` sampled at that same posedge is written at wr_ptr.
  - Latency: cap_valid and level update one clock after the capturing edge.
- Read:
  - Show-ahead: cap_data reflects mem[rd_ptr] combinationally; value is don't-care when empty.
  - Pop occurs at a posedge where cap_valid & cap_ready; rd_ptr advances.
- Pointers: log2(DEPTH) bits each, natural wrap-around at DEPTH.
- Boundary cases:
  - Push while not full: accepted.
  - Push while full without a same-cycle pop: event dropped, contents unchanged, overflow <= 1.
  - Push while full with a same-cycle pop: both accepted, level stays DEPTH, FIFO order preserved.
  - Pop while empty: impossible, since cap_valid=0; cap_ready is ignored.
  - Push and pop on the same edge when level=1: level stays 1, the new entry becomes the head.
  - clr_ovf and a new overflow on the same edge: set wins, overflow stays 1.
  - clr_ovf alone: overflow <= 0 at the next posedge.
- Status: full, empty and cap_valid are derived from the registered level; no combinational path from trig to the status outputs.

Optional Feature:
- Macro: CAP_WRAP_EXT_EN.
- Defined:
  - Adds a registered wrap counter wrap_cnt[EXT_W-1:0], reset 0, and a count_q register (reset 0).
  - wrap_cnt increments, modulo 2^EXT_W, on every posedge where count_q == all-ones and count == 0.
  - Each entry stores {wrap_cnt_next, count}, so a capture on the same edge as a wrap already carries the incremented value.
  - DW = EXT_W+WIDTH.
  - Wraps caused by an upstream load (non-sequential jump to 0) are also counted; this is intentional.
- Undefined: no wrap logic, DW = WIDTH, cap_data = captured count only.

Test Plan (WIDTH=4, DEPTH=4):
- Reset: assert rst mid-clock with 2 entries stored -> immediately level=0, empty=1, cap_valid=0, overflow=0, cap_data=0.
- Single capture: counter running from 4, trig rises when count=6 -> next cycle cap_valid=1, cap_data=4'd6, level=1; cap_ready=1 for one cycle -> empty=1.
- Overflow: cap_ready=0, trig edges at counts 1,3,5,7,9:
  - After the 4th edge full=1; the 5th edge (9) is dropped and overflow=1.
  - Draining yields 1,3,5,7.
  - clr_ovf pulse -> overflow=0.
- Full with simultaneous push/pop: level=4, cap_ready=1 with a trig edge at count=12 -> level stays 4, drained order ends with 12.
- Edge filtering:
  - trig held high for 10 cycles -> exactly 1 capture.
  - trig held high through reset release -> 0 captures until trig goes low then high.
- CAP_WRAP_EXT_EN:
  - Counter runs 14,15,0,1, trig edge at count=0 -> cap_data=8'h10.
  - Without the macro the same stimulus gives cap_data=4'h0.

Source files
------------

// File: rtl/count_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module  : count_capture_fifo
// Purpose : Captures `count` into a show-ahead FIFO on each rising edge of
//           trig and hands entries to a valid/ready sink. With the macro
//           CAP_WRAP_EXT_EN each entry also carries a counter-wrap tally.
// Rev     : 1.0
// ============================================================================
module count_capture_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int EXT_W = 4,
`ifdef CAP_WRAP_EXT_EN
  localparam int DW   = EXT_W + WIDTH
`else
  localparam int DW   = WIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         count,
  input  logic                     trig,
  input  logic                     clr_ovf,
  input  logic                     cap_ready,
  output logic                     cap_valid,
  output logic [DW-1:0]            cap_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int              AW     = $clog2(DEPTH);
  localparam int              LW     = AW + 1;
  localparam logic [LW-1:0]   C_FULL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || EXT_W < 1) begin : g_cfg_check
    $error("count_capture_fifo: DEPTH must be a power of 2 >= 2 and EXT_W >= 1");
  end

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_trig_q;
  logic             r_overflow;

  logic             w_push_req;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [DW-1:0]    w_wdata;

  assign w_full     = (r_level == C_FULL);
  assign w_empty    = (r_level == '0);
  assign w_push_req = trig & ~r_trig_q;
  assign w_pop      = ~w_empty & cap_ready;
  // A push into a full FIFO survives only if the head leaves on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

`ifdef CAP_WRAP_EXT_EN
  logic [EXT_W-1:0] r_wrap_cnt;
  logic [EXT_W-1:0] w_wrap_next;
  logic [WIDTH-1:0] r_count_q;

  assign w_wrap_next = r_wrap_cnt + EXT_W'((r_count_q == '1) && (count == '0));
  assign w_wdata     = {w_wrap_next, count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_cnt <= '0;
      r_count_q  <= '0;
    end else begin
      r_wrap_cnt <= w_wrap_next;
      r_count_q  <= count;
    end
  end
`else
  assign w_wdata = count;
`endif

  // trig_q resets high so a trig held across reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_trig_q   <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_trig_q <= trig;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  assign cap_valid = ~w_empty;
  assign cap_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_count_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_capture_fifo
// Purpose : Directed and random stimulus for count_capture_fifo, checked
//           against a queue-based reference model. Honours CAP_WRAP_EXT_EN.
// Rev     : 1.0
// ============================================================================
module tb_count_capture_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int EXT_W = 4;
`ifdef CAP_WRAP_EXT_EN
  localparam int DW = EXT_W + WIDTH;
  localparam logic [31:0] C_WRAP_EXP = 32'h10;
`else
  localparam int DW = WIDTH;
  localparam logic [31:0] C_WRAP_EXP = 32'h0;
`endif

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic [WIDTH-1:0] count     = '0;
  logic             trig      = 1'b0;
  logic             clr_ovf   = 1'b0;
  logic             cap_ready = 1'b0;
  logic             cap_valid;
  logic [DW-1:0]    cap_data;
  logic [2:0]       level;
  logic             full;
  logic             empty;
  logic             overflow;

  count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EXT_W(EXT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .trig      (trig),
    .clr_ovf   (clr_ovf),
    .cap_ready (cap_ready),
    .cap_valid (cap_valid),
    .cap_data  (cap_data),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: queued captures, last trig, sticky flag, wrap tally.
  int q[$];
  bit m_tq   = 1'b1;
  bit m_ovf  = 1'b0;
  int m_cq   = 0;
  int m_wrap = 0;
  int cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_data;
    exp_data = (q.size() > 0) ? q[0] : 0;
    chk("level",     32'(level),     32'(q.size()));
    chk("cap_valid", 32'(cap_valid), 32'(q.size() > 0));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("cap_data",  32'(cap_data),  32'(exp_data));
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1ns later.
  task automatic step(input bit t, input bit rdy, input bit clr);
    bit push_req;
    bit pop;
    bit was_full;
    int data;
    trig      = t;
    cap_ready = rdy;
    clr_ovf   = clr;
    count     = 4'(cnt);
    @(posedge clk);
    push_req = t && !m_tq;
    m_tq     = t;
    if (m_cq == 15 && cnt == 0) m_wrap = (m_wrap + 1) % 16;
    m_cq = cnt;
`ifdef CAP_WRAP_EXT_EN
    data = m_wrap * 16 + cnt;
`else
    data = cnt;
`endif
    was_full = (q.size() == DEPTH);
    pop      = (q.size() > 0) && rdy;
    if (pop) q.delete(0);
    if (push_req && (!was_full || pop)) q.push_back(data);
    if (push_req && was_full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    cnt = (cnt + 1) % 16;
    #1;
    check_all();
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases off-edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_ovf  = 1'b0;
    m_wrap = 0;
    m_cq   = 0;
    m_tq   = 1'b1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    check_all();
    #10;
    rst = 1'b0;

    // Single capture at count 6 from a counter running from 4.
    cnt = 4;
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("single_data", 32'(cap_data), 32'd6);
    step(1, 1, 0);

    // Trig held high for 10 cycles gives one capture.
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    chk("held_level", 32'(level), 32'd1);
    step(0, 1, 0);

    // Overflow: edges at counts 1,3,5,7,9 with the sink stalled.
    cnt = 0;
    for (int i = 0; i < 10; i++) step(bit'(cnt % 2), 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 0, 1);

    // Full FIFO with a simultaneous push and pop at count 12.
    cnt = 4;
    for (int i = 0; i < 8; i++) step(bit'((cnt % 2 == 0) && cnt <= 10), 0, 0);
    step(1, 1, 0);
    chk("fullpp_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // Reset with two stored entries.
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    do_reset();

    // Trig held high across reset release.
    step(0, 0, 0);
    step(1, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("held_rst_level", 32'(level), 32'd0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);

    // Wrap 14,15,0 with a capture on the wrapping edge.
    do_reset();
    cnt = 14;
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("wrap_data", 32'(cap_data), C_WRAP_EXP);
    step(0, 1, 0);

    // Random traffic, including counter loads and a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) cnt = $urandom_range(0, 15);
      if (i == 250) do_reset();
      step(bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 99) < ((i < 200) ? 25 : 70)),
           bit'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
